regfile_wb_writer: RTL and testbench

REGFILE_WB_WRITER -- requirements
Module: regfile_wb_writer

---
 rtl/regfile_wb_writer.sv | 199 +++++++++++++++++++
 tb/tb_regfile_wb_writer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_writer.sv
// Register-file write-back arbiter.
// Merges single-cycle pipeline results with buffered multi-cycle unit results
// into one registered write port. A pipeline write squashes older queued
// results to the same register. A starvation counter forces the queue head
// through when the pipeline keeps winning.
module regfile_wb_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        pipe_wr_en,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic [4:0]  q_rs,
    output logic        q_hit,
    output logic        stall,
    output logic        RegWr,
    output logic [4:0]  Rw,
    output logic [31:0] Di,
    output logic [3:0]  fifo_count,
    output logic        err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [CW-1:0] LIM   = CW'(STARVE_LIM);
    localparam logic [PW:0]   DEPTH = (PW + 1)'(FIFO_DEPTH);

    // Queue storage. Squashed entries stay in place as holes until they reach
    // the head, so the queue order never has to be rebuilt.
    logic [FIFO_DEPTH-1:0] valid_q, valid_d;
    logic [4:0]            rd_q   [FIFO_DEPTH];
    logic [31:0]           data_q [FIFO_DEPTH];
    logic [PW-1:0]         hd_q, hd_d, tl_q, tl_d;
    logic [PW:0]           occ_q, occ_d;       // occupied slots, holes included
    logic [CW-1:0]         starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic                  err_q, err_d;
    logic                  regwr_q, regwr_d;
    logic [4:0]            rw_q, rw_d;
    logic [31:0]           di_q, di_d;

    logic                  head_present, head_valid, head_hole;
    logic                  pipe_grant, head_grant, pop, enq;
    logic [FIFO_DEPTH-1:0] hit_vec;
    logic [3:0]            valid_cnt;

    assign head_present = (occ_q != '0);
    assign head_valid   = head_present && valid_q[hd_q];
    assign head_hole    = head_present && !valid_q[hd_q];

    // Per-entry hazard match against the query register.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hit
            assign hit_vec[gi] = valid_q[gi] && (rd_q[gi] == q_rs);
        end
    endgenerate

    assign q_hit = (q_rs != 5'd0) && (|hit_vec);

    // Count only live entries; holes do not count.
    always_comb begin
        valid_cnt = 4'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            valid_cnt = valid_cnt + 4'(valid_q[i]);
        end
    end

    assign fifo_count = valid_cnt;
    // A hole at the head is always discarded this cycle, so its slot is free
    // for the tail even when every physical slot is occupied.
    assign mdu_ready  = (valid_cnt < 4'(FIFO_DEPTH)) && ((occ_q != DEPTH) || head_hole);

    assign stall = stall_q;
    assign err   = err_q;
    assign RegWr = regwr_q;
    assign Rw    = rw_q;
    assign Di    = di_q;

    // Arbitration, squash, queue bookkeeping and starvation tracking.
    always_comb begin
        valid_d    = valid_q;
        hd_d       = hd_q;
        tl_d       = tl_q;
        occ_d      = occ_q;
        starve_d   = starve_q;
        stall_d    = stall_q;
        err_d      = err_q;
        regwr_d    = 1'b0;
        rw_d       = rw_q;
        di_d       = di_q;
        pipe_grant = 1'b0;
        head_grant = 1'b0;

        if (stall_q) begin
            head_grant = head_valid;
            if (pipe_wr_en) begin
                err_d = 1'b1;
            end
        end else begin
            pipe_grant = pipe_wr_en && (pipe_rd != 5'd0);
            head_grant = !pipe_grant && head_valid;
        end

        pop = head_grant || head_hole;
        // A result to the register the pipeline is writing right now is
        // already stale, so it is accepted but dropped.
        enq = mdu_valid && mdu_ready && (mdu_rd != 5'd0) &&
              !(pipe_grant && (mdu_rd == pipe_rd));

        if (pipe_grant) begin
            regwr_d = 1'b1;
            rw_d    = pipe_rd;
            di_d    = pipe_data;
        end else if (head_grant) begin
            regwr_d = 1'b1;
            rw_d    = rd_q[hd_q];
            di_d    = data_q[hd_q];
        end

        // Clears before the enqueue set: the tail may reuse the head slot.
        if (pop) begin
            valid_d[hd_q] = 1'b0;
            hd_d          = hd_q + PW'(1);
        end
        if (pipe_grant) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (valid_q[i] && (rd_q[i] == pipe_rd)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        if (enq) begin
            valid_d[tl_q] = 1'b1;
            tl_d          = tl_q + PW'(1);
        end
        occ_d = occ_q + (PW + 1)'(enq) - (PW + 1)'(pop);

        // Stall rises on the edge where the blocked count reaches the limit.
        if (head_grant) begin
            starve_d = '0;
            stall_d  = 1'b0;
        end else if (head_valid) begin
            if (starve_q < LIM) begin
                starve_d = starve_q + CW'(1);
            end
            if (starve_q >= LIM - CW'(1)) begin
                stall_d = 1'b1;
            end
        end else begin
            starve_d = '0;
            if (!head_present) begin
                stall_d = 1'b0;
            end
        end
    end

    // Control state and registered write port.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            valid_q  <= '0;
            hd_q     <= '0;
            tl_q     <= '0;
            occ_q    <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            regwr_q  <= 1'b0;
            rw_q     <= 5'd0;
            di_q     <= 32'd0;
        end else begin
            valid_q  <= valid_d;
            hd_q     <= hd_d;
            tl_q     <= tl_d;
            occ_q    <= occ_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            regwr_q  <= regwr_d;
            rw_q     <= rw_d;
            di_q     <= di_d;
        end
    end

    // Payload storage; only meaningful where the matching valid bit is set.
    always_ff @(posedge CLK) begin
        if (enq) begin
            rd_q[tl_q]   <= mdu_rd;
            data_q[tl_q] <= mdu_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Directed bench for the write-back arbiter: pipeline writes, queue fill and
// drain, WAW squash, zero-register writes, starvation stall and reset.
module tb_regfile_wb_writer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        pipe_wr_en;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  q_rs;
    logic        q_hit;
    logic        stall;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] Di;
    logic [3:0]  fifo_count;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    regfile_wb_writer #(.FIFO_DEPTH(4), .STARVE_LIM(3)) dut (
        .CLK(CLK), .Reset(Reset),
        .pipe_wr_en(pipe_wr_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready), .q_rs(q_rs), .q_hit(q_hit), .stall(stall),
        .RegWr(RegWr), .Rw(Rw), .Di(Di), .fifo_count(fifo_count), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        $display("t=%0t RegWr=%0b Rw=%0d Di=%h cnt=%0d stall=%0b err=%0b rdy=%0b hit=%0b",
                 $time, RegWr, Rw, Di, fifo_count, stall, err, mdu_ready, q_hit);
    endtask

    task automatic idle_inputs();
        pipe_wr_en = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
        mdu_valid  = 1'b0; mdu_rd  = 5'd0; mdu_data  = 32'd0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; idle_inputs(); q_rs = 5'd1;
        tick();
        vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL rst_regwr got %0b exp 0", RegWr); end
        vectors++; if (Rw !== 5'd0) begin miscompares++; $display("FAIL rst_rw got %0d exp 0", Rw); end
        vectors++; if (Di !== 32'd0) begin miscompares++; $display("FAIL rst_di got %h exp 0", Di); end
        vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
        vectors++; if (mdu_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %0b exp 1", mdu_ready); end
        vectors++; if (stall !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_stall_err got %0b/%0b exp 0/0", stall, err); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_pipe_write();
        pipe_wr_en = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234;
        tick();
        vectors++; if (RegWr !== 1'b1 || Rw !== 5'd5 || Di !== 32'h1234) begin miscompares++; $display("FAIL pipe_write got %0b/%0d/%h exp 1/5/1234", RegWr, Rw, Di); end
        idle_inputs();
        tick();
        vectors++; if (RegWr !== 1'b0 || Rw !== 5'd5 || Di !== 32'h1234) begin miscompares++; $display("FAIL pipe_hold got %0b/%0d/%h exp 0/5/1234", RegWr, Rw, Di); end
    endtask

    task automatic test_fifo_fill();
        mdu_valid = 1'b1; mdu_rd = 5'd1; mdu_data = 32'h11;
        tick();
        vectors++; if (fifo_count !== 4'd1 || RegWr !== 1'b0) begin miscompares++; $display("FAIL fill1 got cnt %0d regwr %0b exp 1/0", fifo_count, RegWr); end
        mdu_rd = 5'd2; mdu_data = 32'h22; pipe_wr_en = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h2020;
        tick();
        vectors++; if (fifo_count !== 4'd2 || Rw !== 5'd20) begin miscompares++; $display("FAIL fill2 got cnt %0d rw %0d exp 2/20", fifo_count, Rw); end
        mdu_rd = 5'd3; mdu_data = 32'h33; pipe_rd = 5'd21;
        tick();
        vectors++; if (fifo_count !== 4'd3 || stall !== 1'b0) begin miscompares++; $display("FAIL fill3 got cnt %0d stall %0b exp 3/0", fifo_count, stall); end
        mdu_rd = 5'd4; mdu_data = 32'h44; pipe_rd = 5'd22;
        tick();
        vectors++; if (fifo_count !== 4'd4 || stall !== 1'b1) begin miscompares++; $display("FAIL fill4 got cnt %0d stall %0b exp 4/1", fifo_count, stall); end
        pipe_wr_en = 1'b0; mdu_rd = 5'd5; mdu_data = 32'h55;
        vectors++; if (mdu_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %0b exp 0", mdu_ready); end
        tick();
        vectors++; if (RegWr !== 1'b1 || Rw !== 5'd1 || Di !== 32'h11 || fifo_count !== 4'd3) begin miscompares++; $display("FAIL drain1 got %0b/%0d/%h cnt %0d exp 1/1/11 cnt 3", RegWr, Rw, Di, fifo_count); end
        vectors++; if (stall !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL drain1_stall got %0b/%0b exp 0/0", stall, err); end
        mdu_rd = 5'd6; mdu_data = 32'h66;
        vectors++; if (mdu_ready !== 1'b1) begin miscompares++; $display("FAIL refill_ready got %0b exp 1", mdu_ready); end
        tick();
        vectors++; if (Rw !== 5'd2 || Di !== 32'h22 || fifo_count !== 4'd3) begin miscompares++; $display("FAIL drain2 got %0d/%h cnt %0d exp 2/22 cnt 3", Rw, Di, fifo_count); end
        idle_inputs();
        tick();
        vectors++; if (Rw !== 5'd3 || fifo_count !== 4'd2) begin miscompares++; $display("FAIL drain3 got %0d cnt %0d exp 3 cnt 2", Rw, fifo_count); end
        tick();
        vectors++; if (Rw !== 5'd4 || Di !== 32'h44 || fifo_count !== 4'd1) begin miscompares++; $display("FAIL drain4 got %0d/%h cnt %0d exp 4/44 cnt 1", Rw, Di, fifo_count); end
        tick();
        vectors++; if (RegWr !== 1'b1 || Rw !== 5'd6 || Di !== 32'h66 || fifo_count !== 4'd0) begin miscompares++; $display("FAIL drain5 got %0b/%0d/%h cnt %0d exp 1/6/66 cnt 0", RegWr, Rw, Di, fifo_count); end
        tick();
        vectors++; if (RegWr !== 1'b0 || Rw !== 5'd6) begin miscompares++; $display("FAIL drained got %0b/%0d exp 0/6", RegWr, Rw); end
    endtask

    task automatic test_squash();
        q_rs = 5'd7;
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h77;
        pipe_wr_en = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
        tick();
        vectors++; if (Rw !== 5'd3 || fifo_count !== 4'd1 || q_hit !== 1'b1) begin miscompares++; $display("FAIL sq_setup got rw %0d cnt %0d hit %0b exp 3/1/1", Rw, fifo_count, q_hit); end
        mdu_valid = 1'b0; pipe_rd = 5'd7; pipe_data = 32'h7777;
        tick();
        vectors++; if (Rw !== 5'd7 || Di !== 32'h7777 || fifo_count !== 4'd0 || q_hit !== 1'b0) begin miscompares++; $display("FAIL sq_write got rw %0d di %h cnt %0d hit %0b exp 7/7777/0/0", Rw, Di, fifo_count, q_hit); end
        idle_inputs();
        tick();
        vectors++; if (RegWr !== 1'b0 || Di !== 32'h7777) begin miscompares++; $display("FAIL sq_hole got regwr %0b di %h exp 0/7777", RegWr, Di); end
        mdu_valid = 1'b1; mdu_rd = 5'd8; mdu_data = 32'h88;
        pipe_wr_en = 1'b1; pipe_rd = 5'd8; pipe_data = 32'h8888;
        tick();
        vectors++; if (Rw !== 5'd8 || Di !== 32'h8888 || fifo_count !== 4'd0) begin miscompares++; $display("FAIL sq_same got rw %0d di %h cnt %0d exp 8/8888/0", Rw, Di, fifo_count); end
        idle_inputs();
        tick();
        vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL sq_same_after got regwr %0b exp 0", RegWr); end
    endtask

    task automatic test_zero_rd();
        pipe_wr_en = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
        mdu_valid  = 1'b1; mdu_rd  = 5'd0; mdu_data  = 32'hBEEF;
        vectors++; if (mdu_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready got %0b exp 1", mdu_ready); end
        tick();
        vectors++; if (RegWr !== 1'b0 || fifo_count !== 4'd0) begin miscompares++; $display("FAIL zero_rd got regwr %0b cnt %0d exp 0/0", RegWr, fifo_count); end
        idle_inputs();
        tick();
        vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL zero_after got regwr %0b exp 0", RegWr); end
    endtask

    task automatic test_starve();
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
        pipe_wr_en = 1'b1; pipe_rd = 5'd10; pipe_data = 32'hA;
        tick();
        vectors++; if (Rw !== 5'd10 || fifo_count !== 4'd1) begin miscompares++; $display("FAIL st_setup got rw %0d cnt %0d exp 10/1", Rw, fifo_count); end
        mdu_valid = 1'b0; pipe_rd = 5'd11;
        tick();
        pipe_rd = 5'd12;
        tick();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL st_early got stall %0b exp 0", stall); end
        pipe_rd = 5'd13;
        tick();
        vectors++; if (stall !== 1'b1 || Rw !== 5'd13) begin miscompares++; $display("FAIL st_raise got stall %0b rw %0d exp 1/13", stall, Rw); end
        pipe_rd = 5'd14; pipe_data = 32'hE;
        tick();
        vectors++; if (RegWr !== 1'b1 || Rw !== 5'd9 || Di !== 32'h99) begin miscompares++; $display("FAIL st_head got %0b/%0d/%h exp 1/9/99", RegWr, Rw, Di); end
        vectors++; if (err !== 1'b1 || stall !== 1'b0) begin miscompares++; $display("FAIL st_err got err %0b stall %0b exp 1/0", err, stall); end
        idle_inputs();
        tick();
        vectors++; if (RegWr !== 1'b0 || err !== 1'b1 || fifo_count !== 4'd0) begin miscompares++; $display("FAIL st_after got regwr %0b err %0b cnt %0d exp 0/1/0", RegWr, err, fifo_count); end
    endtask

    task automatic test_reset_mid();
        q_rs = 5'd1;
        mdu_valid = 1'b1; mdu_rd = 5'd1; mdu_data = 32'h11;
        tick();
        mdu_rd = 5'd2; mdu_data = 32'h22; pipe_wr_en = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h2020;
        tick();
        mdu_rd = 5'd3; mdu_data = 32'h33; pipe_rd = 5'd21; pipe_data = 32'h2121;
        tick();
        vectors++; if (fifo_count !== 4'd3 || q_hit !== 1'b1) begin miscompares++; $display("FAIL rm_setup got cnt %0d hit %0b exp 3/1", fifo_count, q_hit); end
        idle_inputs();
        Reset = 1'b1;
        #1;
        vectors++; if (RegWr !== 1'b0 || Rw !== 5'd0 || Di !== 32'd0) begin miscompares++; $display("FAIL rm_out got %0b/%0d/%h exp 0/0/0", RegWr, Rw, Di); end
        vectors++; if (fifo_count !== 4'd0 || mdu_ready !== 1'b1 || q_hit !== 1'b0) begin miscompares++; $display("FAIL rm_fifo got cnt %0d rdy %0b hit %0b exp 0/1/0", fifo_count, mdu_ready, q_hit); end
        vectors++; if (err !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL rm_flags got err %0b stall %0b exp 0/0", err, stall); end
        tick();
        Reset = 1'b0;
        pipe_wr_en = 1'b1; pipe_rd = 5'd6; pipe_data = 32'h66;
        tick();
        vectors++; if (RegWr !== 1'b1 || Rw !== 5'd6 || Di !== 32'h66) begin miscompares++; $display("FAIL rm_fresh got %0b/%0d/%h exp 1/6/66", RegWr, Rw, Di); end
        idle_inputs();
        tick();
        vectors++; if (RegWr !== 1'b0 || fifo_count !== 4'd0) begin miscompares++; $display("FAIL rm_stale got regwr %0b cnt %0d exp 0/0", RegWr, fifo_count); end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_fifo_fill();
        test_squash();
        test_zero_rd();
        test_starve();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
